blit_addr_stepper: RTL and testbench
====================================

# blit_addr_stepper

Address stepper for the blitter source/destination path. It loads a 20-bit start address, a signed step and a transfer count. It then produces one address per accepted request, adding the step each time with modulo-2^20 wrap and no carry-out. It sits directly downstream of the 4-bit no-carry adder slices: it registers their sum, and it owns the operand latching and sequencing around them.

## Interface
Parameters:
- AW, 20, address width; a multiple of 4, because the adder is built from 4-bit no-carry slices.
- SW, 8, step width; two's complement, sign-extended to AW.
- CW, 10, transfer count width.

Ports:
- MasterClock  in  1  single clock; all state changes on its rising edge.
- RESETL  in  1  asynchronous active-low reset.
- LD  in  1  load strobe; samples START, STEP and COUNT.
- START  in  AW  start address.
- STEP  in  SW  signed per-transfer increment.
- COUNT  in  CW  number of addresses to issue; 0 means none.
- REQ  in  1  downstream consumes the current ADR this cycle.
- ADR  out  AW  current address; valid while BUSY.
- BUSY  out  1  addresses remain to be issued.
- ACK  out  1  combinational; equals REQ & BUSY & ~LD.
- DONE  out  1  one-cycle pulse after the last address is consumed.

## Operation
- State registers:
  - adr[AW];
  - step_q[SW], latched at LD;
  - rem[CW];
  - FSM state, one of IDLE, RUN, FIN.
- IDLE:
  - LD with COUNT≠0: adr←START, step_q←STEP, rem←COUNT, go to RUN.
  - LD with COUNT=0: adr←START, step_q←STEP, rem←0, go to FIN. No address is issued.
  - REQ is ignored.
- RUN:
  - BUSY=1.
  - On ACK: adr←(adr + sext(step_q)) mod 2^AW and rem←rem−1.
  - If rem was 1 at ACK, go to FIN.
  - With no ACK, all registers hold.
- FIN:
  - DONE=1 for exactly one cycle, then IDLE.
  - adr holds the address that follows the last one issued.
- Priority: LD beats REQ in every state. LD in RUN or FIN restarts immediately, as in IDLE. A LD in FIN suppresses DONE, because the pulse is replaced by the reload.
- Arithmetic:
  - Plain AW-bit modular sum; the carry-out is discarded.
  - The sum is formed as a ripple of AW/4 4-bit no-carry slices with an explicit inter-slice carry. The top slice has no carry-out.
  - Negative steps wrap below 0 to 2^AW−|step|.
  - rem is unsigned and never decremented below 0.

## Timing
- Reset (RESETL low, asynchronous): adr=0, step_q=0, rem=0, state=IDLE. Outputs ADR=0, BUSY=0, ACK=0, DONE=0. Release is synchronous to the next edge.
- LD is sampled at edge N:
  - COUNT≠0: BUSY and valid ADR=START from N+1.
  - COUNT=0: DONE high in cycle N+1 and BUSY stays 0.
- Throughput is one address per cycle with REQ held high. COUNT=k with continuous REQ gives:
  - BUSY for exactly k cycles;
  - DONE in the cycle immediately after;
  - BUSY low in the DONE cycle.
- ADR changes only at an edge where ACK was high, or on LD. It is stable for the whole cycle.
- ACK is combinational from REQ, BUSY and LD, with zero latency. Downstream samples ADR in the cycle ACK is high.
- Gaps in REQ stall the stepper indefinitely with no loss of state.
- Reset asserted mid-RUN: the block returns to the reset values immediately and no DONE is produced.

## Test plan
- Reset: assert RESETL low mid-RUN with ADR=0x12345 → ADR=0, BUSY=0, DONE=0 at once. No DONE after release.
- Basic run: LD with START=0x00100, STEP=+4, COUNT=3, then REQ held high:
  - ACKed ADR sequence is 0x00100, 0x00104, 0x00108;
  - DONE appears on the 4th cycle after LD's edge, then IDLE with adr=0x0010C.
- Wrap and negative step:
  - START=0xFFFFE, STEP=+3, COUNT=2 → ADR 0xFFFFE then 0x00001.
  - START=0x00002, STEP=−4 (0xFC), COUNT=2 → ADR 0x00002 then 0xFFFFE.
- Stall: COUNT=2, REQ pattern 1,0,0,1 → ADR holds at START+step through the two idle cycles, and DONE follows the second ACK.
- Zero count: LD with COUNT=0, START=0x0ABCD → BUSY never rises, DONE is a single pulse at N+1, and ADR reads 0x0ABCD.
- Simultaneous LD and REQ in RUN:
  - rem=5, LD with START=0x40000, STEP=+1, COUNT=1, REQ=1 → ACK=0 that cycle. The next ADR is 0x40000, not the old address plus step.
  - The following ACK then gives DONE.

Source files
------------

// File: rtl/blit_addr_stepper_if.sv
// Handshake/bus bundle for the blitter address stepper.
// The master side loads and consumes addresses. The slave side is the stepper.
interface blit_addr_stepper_if #(
  parameter int AW = 20,
  parameter int SW = 8,
  parameter int CW = 10
) ();
  logic          LD;
  logic [AW-1:0] START;
  logic [SW-1:0] STEP;
  logic [CW-1:0] COUNT;
  logic          REQ;
  logic [AW-1:0] ADR;
  logic          BUSY;
  logic          ACK;
  logic          DONE;

  modport master (
    output LD, START, STEP, COUNT, REQ,
    input  ADR, BUSY, ACK, DONE
  );

  modport slave (
    input  LD, START, STEP, COUNT, REQ,
    output ADR, BUSY, ACK, DONE
  );
endinterface

// File: rtl/blit_addr_stepper.sv
// Blitter address stepper: issues COUNT addresses from START, advancing by a signed STEP.
// The address advances on each acknowledged request and wraps modulo 2^AW.
module blit_addr_stepper #(
  parameter int AW = 20,
  parameter int SW = 8,
  parameter int CW = 10
) (
  input  logic                MasterClock,
  input  logic                RESETL,
  blit_addr_stepper_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int NS = AW / 4;

  state_t        state;
  logic [AW-1:0] adr;
  logic [SW-1:0] step_q;
  logic [CW-1:0] rem;

  logic [AW-1:0] step_ext;
  logic [AW-1:0] adr_next;
  logic [NS-1:0] carry;
  logic          busy;
  logic          ack;

  assign step_ext = {{(AW-SW){step_q[SW-1]}}, step_q};

  // Ripple of 4-bit no-carry slices. Only the inter-slice carry is explicit.
  // The top slice drops its carry-out, which gives the modulo-2^AW wrap.
  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < NS; gi++) begin : g_slice
    if (gi < NS - 1) begin : g_mid
      assign {carry[gi+1], adr_next[4*gi +: 4]} =
        {1'b0, adr[4*gi +: 4]} + {1'b0, step_ext[4*gi +: 4]} + {4'b0000, carry[gi]};
    end else begin : g_top
      assign adr_next[4*gi +: 4] =
        adr[4*gi +: 4] + step_ext[4*gi +: 4] + {3'b000, carry[gi]};
    end
  end

  assign busy = (state == RUN);

  // A load in the same cycle wins over a request, so it must block ACK.
  assign ack  = bus.REQ & busy & ~bus.LD;

  assign bus.ADR  = adr;
  assign bus.BUSY = busy;
  assign bus.ACK  = ack;
  // A reload during the FIN cycle replaces the completion pulse.
  assign bus.DONE = (state == FIN) & ~bus.LD;

  // NOTE: state registers use non-blocking assignments only. Every register
  // then sees the pre-edge value of the others, whatever the statement order.
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      state  <= IDLE;
      adr    <= '0;
      step_q <= '0;
      rem    <= '0;
    end else if (bus.LD) begin
      adr    <= bus.START;
      step_q <= bus.STEP;
      rem    <= bus.COUNT;
      state  <= (bus.COUNT != '0) ? RUN : FIN;
    end else begin
      case (state)
        RUN: begin
          if (ack) begin
            adr <= adr_next;
            if (rem != '0) begin
              rem <= rem - CW'(1);
            end
            if (rem == CW'(1)) begin
              state <= FIN;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blit_addr_stepper.sv
// Self-checking bench for blit_addr_stepper. The scoreboard queue holds the expected ACKed addresses.
// Each LD pushes the addresses it should produce, and a monitor pops one per observed ACK.
module tb_blit_addr_stepper;

  localparam int AW = 20;
  localparam int SW = 8;
  localparam int CW = 10;

  logic clk;
  logic rst_n;

  blit_addr_stepper_if #(.AW(AW), .SW(SW), .CW(CW)) bus ();

  blit_addr_stepper #(.AW(AW), .SW(SW), .CW(CW)) dut (
    .MasterClock (clk),
    .RESETL      (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_q[$];

  // Scoreboard monitor: every ACK must match the next expected address.
  always @(negedge clk) begin
    if (bus.ACK === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_ack: got ADR=%05h with no address expected", bus.ADR);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        if (bus.ADR !== e) begin
          n_fail++;
          $display("FAIL sb_adr: got %05h expected %05h", bus.ADR, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a load for the current cycle and rebuild the expected sequence.
  task automatic drive_ld(input logic [AW-1:0] start, input logic [SW-1:0] step, input int count);
    logic [AW-1:0] a;
    logic [AW-1:0] s;
    bus.LD    = 1'b1;
    bus.START = start;
    bus.STEP  = step;
    bus.COUNT = CW'(count);
    exp_q.delete();
    a = start;
    s = {{(AW-SW){step[SW-1]}}, step};
    for (int i = 0; i < count; i++) begin
      exp_q.push_back(a);
      a = a + s;
    end
  endtask

  // Load, then leave the bench at cycle N+1, just after edge N sampled LD.
  task automatic do_load(input logic [AW-1:0] start, input logic [SW-1:0] step, input int count);
    tick();
    drive_ld(start, step, count);
    tick();
    bus.LD = 1'b0;
  endtask

  task automatic check_sb_empty(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_sb_left: got %0d pending addresses expected 0", name, exp_q.size());
    end
  endtask

  // Hold REQ high for k addresses, then check the DONE pulse and the final ADR.
  task automatic run_cont(input int k, input logic [AW-1:0] final_adr, input string name);
    bus.REQ = 1'b1;
    for (int i = 0; i <= k + 1; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.BUSY !== (i < k)) begin
        n_fail++;
        $display("FAIL %s_busy[%0d]: got %b expected %b", name, i, bus.BUSY, (i < k));
      end
      n_checks++;
      if (bus.DONE !== (i == k)) begin
        n_fail++;
        $display("FAIL %s_done[%0d]: got %b expected %b", name, i, bus.DONE, (i == k));
      end
      if (i >= k) begin
        n_checks++;
        if (bus.ADR !== final_adr) begin
          n_fail++;
          $display("FAIL %s_final_adr[%0d]: got %05h expected %05h", name, i, bus.ADR, final_adr);
        end
      end
      tick();
    end
    bus.REQ = 1'b0;
    check_sb_empty(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.ADR, bus.BUSY, bus.ACK, bus.DONE} !== {20'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: got ADR=%05h BUSY=%b ACK=%b DONE=%b expected 0", bus.ADR, bus.BUSY, bus.ACK, bus.DONE);
    end
    tick();
    rst_n = 1'b1;
    tick();
    // Reset asserted in the middle of a run.
    bus.REQ = 1'b0;
    do_load(20'h12345, 8'h01, 10);
    @(negedge clk);
    n_checks++;
    if (bus.BUSY !== 1'b1 || bus.ADR !== 20'h12345) begin
      n_fail++;
      $display("FAIL reset_prerun: got BUSY=%b ADR=%05h expected 1 12345", bus.BUSY, bus.ADR);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ADR !== 20'h0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: got ADR=%05h BUSY=%b DONE=%b expected 0 0 0", bus.ADR, bus.BUSY, bus.DONE);
    end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got DONE=%b BUSY=%b expected 0 0", i, bus.DONE, bus.BUSY);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    bus.REQ = 1'b1;
    do_load(20'h00100, 8'h04, 3);
    run_cont(3, 20'h0010C, "basic");
  endtask

  task automatic test_wrap();
    do_load(20'hFFFFE, 8'h03, 2);
    run_cont(2, 20'h00004, "wrap_pos");
    do_load(20'h00002, 8'hFC, 2);
    run_cont(2, 20'hFFFFA, "wrap_neg");
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    pat = 4'b1001;
    bus.REQ = 1'b0;
    do_load(20'h00200, 8'h10, 2);
    for (int i = 0; i < 4; i++) begin
      bus.REQ = pat[3-i];
      @(negedge clk);
      n_checks++;
      if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_busy[%0d]: got BUSY=%b DONE=%b expected 1 0", i, bus.BUSY, bus.DONE);
      end
      n_checks++;
      if (bus.ADR !== ((i == 0) ? 20'h00200 : 20'h00210)) begin
        n_fail++;
        $display("FAIL stall_adr[%0d]: got %05h expected %05h", i, bus.ADR, (i == 0) ? 20'h00200 : 20'h00210);
      end
      tick();
    end
    bus.REQ = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0 || bus.ADR !== 20'h00220) begin
      n_fail++;
      $display("FAIL stall_done: got DONE=%b BUSY=%b ADR=%05h expected 1 0 00220", bus.DONE, bus.BUSY, bus.ADR);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_done_width: got %b expected 0", bus.DONE);
    end
    check_sb_empty("stall");
  endtask

  task automatic test_zero_count();
    bus.REQ = 1'b1;
    do_load(20'h0ABCD, 8'h05, 0);
    @(negedge clk);
    n_checks++;
    if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0 || bus.ACK !== 1'b0 || bus.ADR !== 20'h0ABCD) begin
      n_fail++;
      $display("FAIL zero_done: got DONE=%b BUSY=%b ACK=%b ADR=%05h expected 1 0 0 0abcd", bus.DONE, bus.BUSY, bus.ACK, bus.ADR);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.ADR !== 20'h0ABCD) begin
        n_fail++;
        $display("FAIL zero_after[%0d]: got DONE=%b BUSY=%b ADR=%05h expected 0 0 0abcd", i, bus.DONE, bus.BUSY, bus.ADR);
      end
      tick();
    end
    bus.REQ = 1'b0;
    check_sb_empty("zero");
  endtask

  task automatic test_ld_over_req();
    bus.REQ = 1'b1;
    do_load(20'h01000, 8'h01, 5);
    // In RUN with rem=5, reload while REQ is high.
    drive_ld(20'h40000, 8'h01, 1);
    @(negedge clk);
    n_checks++;
    if (bus.ACK !== 1'b0 || bus.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL ldreq_ack: got ACK=%b BUSY=%b expected 0 1", bus.ACK, bus.BUSY);
    end
    tick();
    bus.LD = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.ADR !== 20'h40000 || bus.ACK !== 1'b1) begin
      n_fail++;
      $display("FAIL ldreq_reload: got ADR=%05h ACK=%b expected 40000 1", bus.ADR, bus.ACK);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0 || bus.ADR !== 20'h40001) begin
      n_fail++;
      $display("FAIL ldreq_done: got DONE=%b BUSY=%b ADR=%05h expected 1 0 40001", bus.DONE, bus.BUSY, bus.ADR);
    end
    tick();
    bus.REQ = 1'b0;
    check_sb_empty("ldreq");
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.LD    = 1'b0;
    bus.START = '0;
    bus.STEP  = '0;
    bus.COUNT = '0;
    bus.REQ   = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_count();
    test_ld_over_req();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
